video_pattern_source: RTL and testbench

VIDEO_PATTERN_SOURCE -- requirements
Module: video_pattern_source

---
 rtl/video_pattern_source.sv | 176 +++++++++++++++++
 tb/tb_video_pattern_source.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_source.sv
// rtl/video_pattern_source.sv - raster test-pattern generator with valid/ready pixel output
module video_pattern_source #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int FRAME_GAP = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] patch_color,
  input  logic        video_ready,
  output logic        video_valid,
  output logic [11:0] video_data,
  output logic        sof,
  output logic        eol,
  output logic [9:0]  x_count,
  output logic [8:0]  y_count,
  output logic [7:0]  frame_count,
  output logic        frame_done
);

  // Bars are one eighth of the line; the patch is a 32x32 square around the
  // raster centre (304..335 x 224..255 at 640x480).
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam int PX0   = H_ACTIVE / 2 - 16;
  localparam int PX1   = H_ACTIVE / 2 + 15;
  localparam int PY0   = V_ACTIVE / 2 - 16;
  localparam int PY1   = V_ACTIVE / 2 + 15;
  localparam int GW    = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [1:0]    sel_q, sel_nxt;
  logic [11:0]   col_q, col_nxt;
  logic          valid_nxt, sof_nxt, eol_nxt, done_nxt;
  logic [11:0]   data_nxt;
  logic [9:0]    x_nxt, x_adv;
  logic [8:0]    y_nxt, y_adv;
  logic [7:0]    fc_nxt;
  logic          xfer, last_px, frame_end, start_frame;

  function automatic logic [11:0] pixel_of(input logic [9:0] px, input logic [8:0] py,
                                           input logic [1:0] sel, input logic [11:0] col,
                                           input logic [3:0] fc);
    int          bar;
    logic [11:0] d;
    bar = int'(px) / BAR_W;
    d   = 12'h000;
    case (sel)
      2'd0: d = col;
      2'd1: begin
        case (bar)
          0:       d = 12'hFFF;
          1:       d = 12'hFF0;
          2:       d = 12'h0FF;
          3:       d = 12'h0F0;
          4:       d = 12'hF0F;
          5:       d = 12'hF00;
          6:       d = 12'h00F;
          default: d = 12'h000;
        endcase
      end
      2'd2: begin
        if (int'(px) >= PX0 && int'(px) <= PX1 && int'(py) >= PY0 && int'(py) <= PY1)
          d = col;
      end
      default: d = {px[9:6], py[8:5], fc};
    endcase
    return d;
  endfunction

  assign xfer        = video_valid & video_ready;
  assign last_px     = (x_count == 10'(H_ACTIVE - 1)) && (y_count == 9'(V_ACTIVE - 1));
  assign frame_end   = (state == S_ACTIVE) && xfer && last_px;
  assign start_frame = enable && ((state == S_IDLE) ||
                                  (state == S_GAP && gap_cnt == '0) ||
                                  (frame_end && FRAME_GAP == 0));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state selection: a started frame always runs to its last pixel
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (enable) state_nxt = S_ACTIVE;
      S_ACTIVE: if (frame_end) begin
        if (FRAME_GAP == 0) state_nxt = enable ? S_ACTIVE : S_IDLE;
        else                state_nxt = S_GAP;
      end
      S_GAP:    if (gap_cnt == '0) state_nxt = enable ? S_ACTIVE : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the per-frame latches
  always_comb begin
    valid_nxt = video_valid;
    data_nxt  = video_data;
    sof_nxt   = sof;
    eol_nxt   = eol;
    x_nxt     = x_count;
    y_nxt     = y_count;
    fc_nxt    = frame_count;
    done_nxt  = 1'b0;
    gap_nxt   = gap_cnt;
    sel_nxt   = sel_q;
    col_nxt   = col_q;
    x_adv     = (x_count == 10'(H_ACTIVE - 1)) ? 10'd0 : x_count + 10'd1;
    y_adv     = (x_count == 10'(H_ACTIVE - 1)) ? y_count + 9'd1 : y_count;

    if (frame_end) begin
      valid_nxt = 1'b0;
      sof_nxt   = 1'b0;
      eol_nxt   = 1'b0;
      done_nxt  = 1'b1;
      fc_nxt    = frame_count + 8'd1;
      gap_nxt   = GW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);
    end else if (state == S_ACTIVE && xfer) begin
      x_nxt    = x_adv;
      y_nxt    = y_adv;
      sof_nxt  = 1'b0;
      eol_nxt  = (x_adv == 10'(H_ACTIVE - 1));
      data_nxt = pixel_of(x_adv, y_adv, sel_q, col_q, frame_count[3:0]);
    end

    if (state == S_GAP && gap_cnt != '0) gap_nxt = gap_cnt - 1'b1;

    if (start_frame) begin
      valid_nxt = 1'b1;
      x_nxt     = 10'd0;
      y_nxt     = 9'd0;
      sof_nxt   = 1'b1;
      eol_nxt   = (H_ACTIVE == 1);
      sel_nxt   = pattern_sel;
      col_nxt   = patch_color;
      data_nxt  = pixel_of(10'd0, 9'd0, pattern_sel, patch_color, fc_nxt[3:0]);
    end
  end

  // Output and latch registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      video_valid <= 1'b0;
      video_data  <= 12'h000;
      sof         <= 1'b0;
      eol         <= 1'b0;
      x_count     <= 10'd0;
      y_count     <= 9'd0;
      frame_count <= 8'd0;
      frame_done  <= 1'b0;
      gap_cnt     <= '0;
      sel_q       <= 2'd0;
      col_q       <= 12'h000;
    end else begin
      video_valid <= valid_nxt;
      video_data  <= data_nxt;
      sof         <= sof_nxt;
      eol         <= eol_nxt;
      x_count     <= x_nxt;
      y_count     <= y_nxt;
      frame_count <= fc_nxt;
      frame_done  <= done_nxt;
      gap_cnt     <= gap_nxt;
      sel_q       <= sel_nxt;
      col_q       <= col_nxt;
    end
  end

endmodule

// File: tb/tb_video_pattern_source.sv
// tb/tb_video_pattern_source.sv - scoreboard bench for video_pattern_source
module tb_video_pattern_source;

  localparam int HA = 64, VA = 40, GA = 16;
  localparam int HB = 8,  VB = 2,  GB = 0;
  localparam logic [11:0] BAR_TAB [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                          12'hF0F, 12'hF00, 12'h00F, 12'h000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n_a, enable_a, ready_a, valid_a, sof_a, eol_a, done_a;
  logic [1:0]  sel_a;
  logic [11:0] col_a, data_a;
  logic [9:0]  x_a;
  logic [8:0]  y_a;
  logic [7:0]  fc_a;

  logic        reset_n_b, enable_b, ready_b, valid_b, sof_b, eol_b, done_b;
  logic [1:0]  sel_b;
  logic [11:0] col_b, data_b;
  logic [9:0]  x_b;
  logic [8:0]  y_b;
  logic [7:0]  fc_b;

  video_pattern_source #(.H_ACTIVE(HA), .V_ACTIVE(VA), .FRAME_GAP(GA)) dut_a (
    .clk(clk), .reset_n(reset_n_a), .enable(enable_a), .pattern_sel(sel_a),
    .patch_color(col_a), .video_ready(ready_a), .video_valid(valid_a),
    .video_data(data_a), .sof(sof_a), .eol(eol_a), .x_count(x_a), .y_count(y_a),
    .frame_count(fc_a), .frame_done(done_a));

  video_pattern_source #(.H_ACTIVE(HB), .V_ACTIVE(VB), .FRAME_GAP(GB)) dut_b (
    .clk(clk), .reset_n(reset_n_b), .enable(enable_b), .pattern_sel(sel_b),
    .patch_color(col_b), .video_ready(ready_b), .video_valid(valid_b),
    .video_data(data_b), .sof(sof_b), .eol(eol_b), .x_count(x_b), .y_count(y_b),
    .frame_count(fc_b), .frame_done(done_b));

  int total = 0, bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference pixel from the pattern rules, for the dut_a geometry
  function automatic logic [11:0] ref_pixel(int x, int y, int sel, logic [11:0] col, int fc);
    logic [11:0] r;
    case (sel)
      0: r = col;
      1: r = BAR_TAB[x / (HA / 8)];
      2: r = (x >= HA/2 - 16 && x <= HA/2 + 15 && y >= VA/2 - 16 && y <= VA/2 + 15) ? col : 12'h000;
      default: r = {4'(x / 64), 4'(y / 32), 4'(fc % 16)};
    endcase
    return r;
  endfunction

  logic [32:0] exp_q[$];

  task automatic push_frame(int sel, logic [11:0] col, int fc);
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        exp_q.push_back({10'(x), 9'(y), ref_pixel(x, y, sel, col, fc),
                         (x == 0 && y == 0), (x == HA - 1)});
  endtask

  // Monitor for dut_a: scoreboard pops, stall stability, event counts, gap length
  int          sof_cnt_a = 0, eol_cnt_a = 0, done_cnt_a = 0, xfer_cnt_a = 0;
  int          gap_len = 0, last_gap = -1;
  logic        in_gap = 1'b0, prev_stall = 1'b0;
  logic [32:0] prev_px;
  always @(negedge clk) begin
    logic [32:0] act, e;
    if (!reset_n_a) begin
      prev_stall = 1'b0;
      in_gap     = 1'b0;
    end else begin
      act = {x_a, y_a, data_a, sof_a, eol_a};
      if (prev_stall) begin
        if (!valid_a) check("stall_valid_held", 64'(valid_a), 64'd1);
        else          check("stall_pixel_held", 64'(act), 64'(prev_px));
      end
      if (in_gap) begin
        if (valid_a) begin last_gap = gap_len; in_gap = 1'b0; end
        else gap_len++;
      end
      if (valid_a && ready_a) begin
        xfer_cnt_a++;
        if (sof_a) sof_cnt_a++;
        if (eol_a) eol_cnt_a++;
        if (exp_q.size() == 0) check("unexpected_pixel", 64'(act), 64'd0);
        else begin
          e = exp_q.pop_front();
          check("pixel", 64'(act), 64'(e));
          if (e[32:23] == 10'(HA - 1) && e[22:14] == 9'(VA - 1)) begin
            in_gap  = 1'b1;
            gap_len = 0;
          end
        end
      end
      if (done_a) done_cnt_a++;
      prev_stall = valid_a && !ready_a;
      prev_px    = act;
    end
  end

  // Monitor for dut_b: back-to-back ramp frames, counter wrap
  int k_b = 0, done_cnt_b = 0;
  always @(negedge clk) begin
    int f, p;
    if (reset_n_b) begin
      if (valid_b && ready_b) begin
        f = k_b / (HB * VB);
        p = k_b % (HB * VB);
        check("b_pixel", 64'({x_b, y_b, data_b, sof_b, eol_b}),
              64'({10'(p % HB), 9'(p / HB), 12'(f % 16), (p == 0), (p % HB == HB - 1)}));
        k_b++;
      end
      if (done_b) begin
        check("b_frame_count", 64'(fc_b), 64'((done_cnt_b + 1) % 256));
        if (done_cnt_b < 256) check("b_restart_on_done", 64'({valid_b, sof_b}), 64'd3);
        else                  check("b_stop_on_done", 64'(valid_b), 64'd0);
        done_cnt_b++;
      end
    end
  end

  // Ready driver for dut_a
  logic rnd_ready = 1'b0;
  initial begin
    ready_a = 1'b1;
    forever begin
      @(posedge clk); #1;
      ready_a = rnd_ready ? 1'($urandom % 2) : 1'b1;
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_sof_a(int target, int budget);
    int c = 0;
    while (sof_cnt_a < target && c < budget) begin tick(1); c++; end
    check("wait_sof", 64'(sof_cnt_a), 64'(target));
  endtask

  task automatic wait_done_a(int target, int budget);
    int c = 0;
    while (done_cnt_a < target && c < budget) begin tick(1); c++; end
    check("wait_frame_done", 64'(done_cnt_a), 64'(target));
  endtask

  // Stimulus for dut_b
  logic b_finished = 1'b0;
  initial begin
    int c;
    reset_n_b = 1'b0; enable_b = 1'b0; sel_b = 2'd3; col_b = 12'h000; ready_b = 1'b1;
    tick(3);
    reset_n_b = 1'b1;
    enable_b  = 1'b1;
    c = 0;
    while (done_cnt_b < 256 && c < 10000) begin tick(1); c++; end
    enable_b = 1'b0;
    c = 0;
    while (done_cnt_b < 257 && c < 100) begin tick(1); c++; end
    tick(10);
    check("b_pixel_total", 64'(k_b), 64'(257 * HB * VB));
    check("b_final_frame_count", 64'(fc_b), 64'd1);
    check("b_idle_after_stop", 64'(valid_b), 64'd0);
    b_finished = 1'b1;
  end

  // Stimulus for dut_a
  initial begin
    int d0, s0, e0, x0, c;
    logic [11:0] col;
    reset_n_a = 1'b0; enable_a = 1'b0; sel_a = 2'd0; col_a = 12'h000;
    tick(3);
    check("reset_outputs", 64'({valid_a, data_a, sof_a, eol_a, x_a, y_a, fc_a, done_a}), 64'd0);
    reset_n_a = 1'b1;
    tick(3);
    check("idle_without_enable", 64'(valid_a), 64'd0);

    // solid red, ready held high; enable dropped right after sof
    sel_a = 2'd0; col_a = 12'hF00;
    push_frame(0, 12'hF00, 0);
    s0 = sof_cnt_a; e0 = eol_cnt_a; d0 = done_cnt_a;
    enable_a = 1'b1;
    wait_sof_a(s0 + 1, 10);
    enable_a = 1'b0;
    wait_done_a(d0 + 1, 6000);
    check("t1_frame_count", 64'(fc_a), 64'd1);
    check("t1_eol_count", 64'(eol_cnt_a - e0), 64'(VA));
    x0 = xfer_cnt_a;
    tick(40);
    check("t1_sof_count", 64'(sof_cnt_a - s0), 64'd1);
    check("t1_single_done", 64'(done_cnt_a - d0), 64'd1);
    check("t1_idle_no_pixels", 64'(xfer_cnt_a - x0), 64'd0);

    // centre patch in green
    sel_a = 2'd2; col_a = 12'h0F0;
    push_frame(2, 12'h0F0, 1);
    s0 = sof_cnt_a; d0 = done_cnt_a;
    enable_a = 1'b1;
    wait_sof_a(s0 + 1, 10);
    enable_a = 1'b0;
    wait_done_a(d0 + 1, 6000);
    check("t2_frame_count", 64'(fc_a), 64'd2);
    tick(20);

    // colour bars with random ready; selection inputs scrambled mid-frame
    col = 12'($urandom);
    sel_a = 2'd1; col_a = col;
    push_frame(1, col, 2);
    rnd_ready = 1'b1;
    s0 = sof_cnt_a; d0 = done_cnt_a; x0 = xfer_cnt_a;
    enable_a = 1'b1;
    wait_sof_a(s0 + 1, 10);
    enable_a = 1'b0;
    c = 0;
    while (done_cnt_a < d0 + 1 && c < 20000) begin
      sel_a = 2'($urandom); col_a = 12'($urandom);
      tick(1); c++;
    end
    check("t3_frame_done", 64'(done_cnt_a), 64'(d0 + 1));
    check("t3_pixel_total", 64'(xfer_cnt_a - x0), 64'(HA * VA));
    check("t3_frame_count", 64'(fc_a), 64'd3);
    tick(20);

    // two back-to-back ramp frames, gap length between them
    sel_a = 2'd3; col_a = 12'h000;
    push_frame(3, 12'h000, 3);
    push_frame(3, 12'h000, 4);
    s0 = sof_cnt_a; d0 = done_cnt_a;
    enable_a = 1'b1;
    wait_sof_a(s0 + 2, 20000);
    enable_a = 1'b0;
    check("t4_gap_cycles", 64'(last_gap), 64'(GA));
    wait_done_a(d0 + 2, 20000);
    check("t4_frame_count", 64'(fc_a), 64'd5);
    rnd_ready = 1'b0;
    tick(20);

    // reset mid-frame, then a clean restart
    col = 12'($urandom);
    sel_a = 2'd0; col_a = col;
    push_frame(0, col, 5);
    x0 = xfer_cnt_a;
    enable_a = 1'b1;
    c = 0;
    while (xfer_cnt_a < x0 + 1000 && c < 5000) begin tick(1); c++; end
    check("t5_reached_midframe", 64'(xfer_cnt_a - x0), 64'd1000);
    #2 reset_n_a = 1'b0;
    #1 check("t5_async_reset", 64'({valid_a, data_a, sof_a, eol_a, x_a, y_a, fc_a, done_a}), 64'd0);
    exp_q.delete();
    col = 12'($urandom);
    col_a = col;
    push_frame(0, col, 0);
    tick(2);
    s0 = sof_cnt_a; d0 = done_cnt_a;
    reset_n_a = 1'b1;
    wait_sof_a(s0 + 1, 10);
    enable_a = 1'b0;
    wait_done_a(d0 + 1, 6000);
    check("t5_frame_count", 64'(fc_a), 64'd1);
    tick(20);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    c = 0;
    while (!b_finished && c < 20000) begin tick(1); c++; end
    check("b_finished", 64'(b_finished), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
